// File: rtl/inst_encoder_loader.sv
// Boot-time instruction image builder: packs symbolic instruction requests into
// 32-bit MIPS words and writes them sequentially into instruction memory from word 0.
module inst_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              req_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_CAPACITY = 2'b10;

  // Count value whose increment fills the memory exactly.
  localparam logic [ADDR_W:0] COUNT_LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [1:0]        err_code_reg;
  logic              last_reg;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              handshake;
  logic              full_next;

  always_comb begin
    enc_word  = 32'h0000_0000;
    enc_legal = 1'b1;
    case (req_kind)
      4'd0:    enc_word = {6'b000000, req_rs, req_rt, req_rd, req_shamt, req_funct};
      4'd1:    enc_word = {6'b001000, req_rs, req_rt, req_imm};
      4'd2:    enc_word = {6'b001100, req_rs, req_rt, req_imm};
      4'd3:    enc_word = {6'b100011, req_rs, req_rt, req_imm};
      4'd4:    enc_word = {6'b101011, req_rs, req_rt, req_imm};
      4'd5:    enc_word = {6'b000010, req_target};
      4'd6:    enc_word = {6'b000100, req_rs, req_rt, req_imm};
      4'd7:    enc_word = {6'b000101, req_rs, req_rt, req_imm};
      4'd8:    enc_word = 32'h0000_0000;
      default: enc_legal = 1'b0;
    endcase
  end

  assign handshake = (state_reg == ACCEPT) && req_valid;
  assign full_next = (count_reg == COUNT_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) state_next = ACCEPT;
      end
      ACCEPT: begin
        if (handshake) state_next = enc_legal ? WRITE : ERROR;
      end
      WRITE: begin
        if (last_reg)       state_next = DONE;
        else if (full_next) state_next = ERROR;
        else                state_next = ACCEPT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      addr_reg     <= '0;
      wdata_reg    <= 32'h0000_0000;
      err_code_reg <= ERR_NONE;
      last_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE, DONE, ERROR: begin
          if (start) begin
            count_reg    <= '0;
            err_code_reg <= ERR_NONE;
          end
        end
        ACCEPT: begin
          if (handshake) begin
            last_reg <= req_last;
            if (enc_legal) begin
              wdata_reg <= enc_word;
              addr_reg  <= count_reg[ADDR_W-1:0];
            end else begin
              err_code_reg <= ERR_ILLEGAL;
            end
          end
        end
        WRITE: begin
          count_reg <= count_reg + 1'b1;
          if (!last_reg && full_next) err_code_reg <= ERR_CAPACITY;
        end
        default: ;
      endcase
    end
  end

  // Decoded straight from the state register so an async reset drops them at once.
  assign req_ready = (state_reg == ACCEPT);
  assign mem_we    = (state_reg == WRITE);
  assign busy      = (state_reg == ACCEPT) || (state_reg == WRITE);
  assign done      = (state_reg == DONE);
  assign err       = (state_reg == ERROR);
  assign err_code  = err_code_reg;
  assign count     = count_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: vector table of encodings plus
// hand-written sequences for error, capacity, back-pressure and reset corners.
`timescale 1ns/1ps
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_kind = '0;
  logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
  logic [5:0]  req_funct = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;
  logic        req_last = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [8:0]  count;

  // Small-capacity instance for the capacity-exhaustion corner.
  logic        start2 = 1'b0;
  logic        req_valid2 = 1'b0;
  logic        req_ready2;
  logic        mem_we2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic        busy2, done2, err2;
  logic [1:0]  err_code2;
  logic [2:0]  count2;

  always #5 clk = ~clk;

  inst_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_funct(req_funct), .req_imm(req_imm),
    .req_target(req_target), .req_last(req_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .count(count)
  );

  inst_encoder_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_funct(req_funct), .req_imm(req_imm),
    .req_target(req_target), .req_last(req_last), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .busy(busy2), .done(done2), .err(err2), .err_code(err_code2),
    .count(count2)
  );

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [12];

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  logic [1:0]  wr2_addr [$];

  always @(posedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (mem_we2) wr2_addr.push_back(mem_addr2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_fields(input vec_t v, input logic last);
    req_kind   = v.kind;
    req_rs     = v.rs;
    req_rt     = v.rt;
    req_rd     = v.rd;
    req_shamt  = v.shamt;
    req_funct  = v.funct;
    req_imm    = v.imm;
    req_target = v.target;
    req_last   = last;
  endtask

  // Presents one request, waits (bounded) for ready, completes the handshake
  // and checks that mem_we is up in the very next cycle.
  task automatic send(input vec_t v, input logic last, input string tag);
    int n = 0;
    drive_fields(v, last);
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      chk({tag, " ready timeout"}, {31'd0, req_ready}, 32'd1);
    end else begin
      tick();
      chk({tag, " mem_we after handshake"}, {31'd0, mem_we}, 32'd1);
    end
    req_valid = 1'b0;
  endtask

  task automatic run_session(input int lo, input int hi, input string tag);
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    for (int k = lo; k <= hi; k++) send(vecs[k], (k == hi), $sformatf("%s req%0d", tag, k));
    tick();
    tick();
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " err"}, {31'd0, err}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " count"}, {23'd0, count}, 32'(hi - lo + 1));
    chk({tag, " write count"}, 32'(wr_addr.size()), 32'(hi - lo + 1));
    for (int k = 0; k < wr_addr.size() && k <= hi - lo; k++) begin
      chk($sformatf("%s addr%0d", tag, k), {24'd0, wr_addr[k]}, 32'(k));
      chk($sformatf("%s word%0d", tag, k), wr_data[k], vecs[lo + k].exp_word);
    end
  endtask

  initial begin
    vecs[0]  = '{4'd1, 5'd0,  5'd8,  5'd0,  5'd0,  6'h00, 16'h0005, 26'h0,       32'h2008_0005};
    vecs[1]  = '{4'd0, 5'd8,  5'd9,  5'd10, 5'd0,  6'h20, 16'h1234, 26'h3ABCDEF, 32'h0109_5020};
    vecs[2]  = '{4'd3, 5'd8,  5'd9,  5'd0,  5'd0,  6'h00, 16'h0004, 26'h0,       32'h8D09_0004};
    vecs[3]  = '{4'd6, 5'd8,  5'd9,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0,       32'h1109_FFFF};
    vecs[4]  = '{4'd5, 5'd31, 5'd31, 5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0000010, 32'h0800_0010};
    vecs[5]  = '{4'd8, 5'd7,  5'd7,  5'd7,  5'd7,  6'h3F, 16'hBEEF, 26'h3FFFFFF, 32'h0000_0000};
    vecs[6]  = '{4'd2, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'h00FF, 26'h0,       32'h3022_00FF};
    vecs[7]  = '{4'd4, 5'd29, 5'd31, 5'd0,  5'd0,  6'h00, 16'h8000, 26'h0,       32'hAFBF_8000};
    vecs[8]  = '{4'd7, 5'd3,  5'd4,  5'd0,  5'd0,  6'h00, 16'hFFFE, 26'h0,       32'h1464_FFFE};
    vecs[9]  = '{4'd0, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0000, 26'h0,       32'h03FF_FFFF};
    vecs[10] = '{4'd5, 5'd5,  5'd5,  5'd5,  5'd5,  6'h15, 16'h5555, 26'h3FFFFFF, 32'h0BFF_FFFF};
    vecs[11] = '{4'd8, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0,       32'h0000_0000};

    // Reset state
    #12;
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done/err", {30'd0, done, err}, 32'd0);
    chk("reset count", {23'd0, count}, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset err_code", {30'd0, err_code}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle req_ready", {31'd0, req_ready}, 32'd0);

    run_session(0, 1, "addi+R");
    run_session(2, 5, "lw/beq/j/nop");
    run_session(0, 11, "full table");

    // Illegal kind as second request
    wr_addr.delete();
    pulse_start();
    send(vecs[0], 1'b0, "ill first");
    begin
      vec_t bad;
      bad = vecs[0];
      bad.kind = 4'd12;
      drive_fields(bad, 1'b0);
      req_valid = 1'b1;
      while (!req_ready) tick();
      tick();
      req_valid = 1'b0;
    end
    chk("ill no mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("ill err", {31'd0, err}, 32'd1);
    chk("ill err_code", {30'd0, err_code}, 32'd1);
    chk("ill count", {23'd0, count}, 32'd1);
    chk("ill writes", 32'(wr_addr.size()), 32'd1);
    pulse_start();
    chk("ill restart err", {31'd0, err}, 32'd0);
    chk("ill restart count", {23'd0, count}, 32'd0);
    chk("ill restart ready", {31'd0, req_ready}, 32'd1);
    chk("ill restart err_code", {30'd0, err_code}, 32'd0);

    // Continuous req_valid with start pulsed during ACCEPT; session ends via table entry last
    wr_addr.delete();
    wr_data.delete();
    req_valid = 1'b1;
    begin
      int k = 0;
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("stream ready cyc%0d", i), {31'd0, req_ready}, 32'(((i % 2) == 0) ? 1 : 0));
        if (req_ready) begin
          drive_fields(vecs[6 + k], (k == 2));
          k++;
        end
        start = (i == 2);
        tick();
      end
    end
    start = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("stream writes", 32'(wr_addr.size()), 32'd3);
    chk("stream count", {23'd0, count}, 32'd3);
    chk("stream done", {31'd0, done}, 32'd1);
    if (wr_data.size() == 3) chk("stream word2", wr_data[2], vecs[8].exp_word);

    // Capacity exhaustion on the 4-word instance
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    drive_fields(vecs[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      req_valid2 = 1'b1;
      while (!req_ready2 && n < 10) begin
        tick();
        n++;
      end
      tick();
      req_valid2 = 1'b0;
    end
    tick();
    chk("cap err", {31'd0, err2}, 32'd1);
    chk("cap err_code", {30'd0, err_code2}, 32'd2);
    chk("cap count", {29'd0, count2}, 32'd4);
    chk("cap writes", 32'(wr2_addr.size()), 32'd4);
    for (int k = 0; k < wr2_addr.size() && k < 4; k++)
      chk($sformatf("cap addr%0d", k), {30'd0, wr2_addr[k]}, 32'(k));
    req_valid2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cap ready low%0d", i), {31'd0, req_ready2}, 32'd0);
      tick();
    end
    req_valid2 = 1'b0;
    chk("cap no fifth write", 32'(wr2_addr.size()), 32'd4);

    // Asynchronous reset between edges during WRITE
    wr_addr.delete();
    pulse_start();
    send(vecs[0], 1'b0, "rst first");
    tick();
    send(vecs[2], 1'b0, "rst second");
    #2 rst_n = 1'b0;
    #1;
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst count", {23'd0, count}, 32'd0);
    tick();
    chk("rst writes", 32'(wr_addr.size()), 32'd1);
    rst_n = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post-rst ignore%0d", i), {30'd0, req_ready, busy}, 32'd0);
    end
    chk("post-rst writes", 32'(wr_addr.size()), 32'd1);
    req_valid = 1'b0;
    pulse_start();
    chk("post-rst start ready", {31'd0, req_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
